// File: rtl/mole_pkg.sv
// Shared types and stage lookup helpers for the mole scheduler.
// Slot state, stage encodings and per-stage timing/concurrency tables.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SHOW = 2'd2
  } slot_state_t;

  localparam logic [1:0] STAGE_1 = 2'b01;
  localparam logic [1:0] STAGE_2 = 2'b10;
  localparam logic [1:0] STAGE_3 = 2'b11;

  // Stage 2'b00 falls through to the stage-1 value.
  function automatic int unsigned stage_pick(
    input logic [1:0]  stage,
    input int unsigned v1,
    input int unsigned v2,
    input int unsigned v3
  );
    case (stage)
      STAGE_2: return v2;
      STAGE_3: return v3;
      default: return v1;
    endcase
  endfunction

  function automatic int unsigned stage_dur(
    input logic [1:0]  stage,
    input int unsigned d1,
    input int unsigned d2,
    input int unsigned d3
  );
    return stage_pick(stage, d1, d2, d3);
  endfunction

  function automatic int unsigned stage_gap(
    input logic [1:0]  stage,
    input int unsigned g1,
    input int unsigned g2,
    input int unsigned g3
  );
    return stage_pick(stage, g1, g2, g3);
  endfunction

  function automatic int unsigned stage_limit(
    input logic [1:0]  stage,
    input int unsigned max_active
  );
    return stage_pick(stage, 1,
                      (max_active < 2) ? max_active : 2,
                      max_active);
  endfunction

endpackage

// File: rtl/mole_slot.sv
// One mole slot: IDLE/WAIT/SHOW state, ms timer and owned hole.
// Raises a spawn request at gap end and holds it until granted.
module mole_slot
  import mole_pkg::*;
#(
  parameter int TW = 10,
  parameter int HW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          allowed,
  input  logic          tick,
  input  logic [TW-1:0] gap,
  input  logic [TW-1:0] dur,
  input  logic          grant,
  input  logic          full,
  input  logic [HW-1:0] spawn_hole,
  input  logic          hit_hit,
  input  logic [HW-1:0] hit_idx,
  output logic          req,
  output logic          expire,
  output logic [HW-1:0] hole
);

  slot_state_t   state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [HW-1:0] hole_n;
  logic          pend, pend_n;
  logic          at_one, hit_own, done;

  assign at_one  = timer == TW'(1);
  assign hit_own = state == SHOW && hit_hit && hole == hit_idx;
  assign expire  = state == SHOW && tick && at_one && !hit_own;
  assign done    = hit_own || expire;
  assign req     = enable && allowed && state == WAIT
                && (pend || (tick && at_one));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      hole  <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      hole  <= hole_n;
      pend  <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    hole_n  = hole;
    pend_n  = pend;
    if (!enable) begin
      state_n = IDLE;
      timer_n = '0;
      hole_n  = '0;
      pend_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (allowed) begin
            state_n = WAIT;
            timer_n = gap;
          end
        end
        WAIT: begin
          if (!allowed) begin
            state_n = IDLE;
            timer_n = '0;
            pend_n  = 1'b0;
          end else if (req && grant) begin
            // A full board leaves the timer at 1: retry on next tick.
            pend_n = 1'b0;
            if (!full) begin
              state_n = SHOW;
              timer_n = dur;
              hole_n  = spawn_hole;
            end
          end else if (req) begin
            pend_n = 1'b1;
          end else if (tick) begin
            timer_n = timer - TW'(1);
          end
        end
        SHOW: begin
          if (done) begin
            state_n = allowed ? WAIT : IDLE;
            timer_n = allowed ? gap : '0;
          end else if (tick) begin
            timer_n = timer - TW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Multi-mole scheduler: tick prescaler, slot array, spawn arbiter,
// hole probe, mole mask and registered hit/expiry event pulses.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int N_HOLES    = 8,
  parameter int MAX_ACTIVE = 3,
  parameter int TICK_DIV   = 1000,
  parameter int DUR_S1     = 1000,
  parameter int DUR_S2     = 750,
  parameter int DUR_S3     = 500,
  parameter int GAP_S1     = 500,
  parameter int GAP_S2     = 250,
  parameter int GAP_S3     = 200,
  parameter int TW         = 10
) (
  input  logic                            clk_1mhz,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [1:0]                      stage,
  input  logic [15:0]                     rand_in,
  input  logic                            hit_valid,
  input  logic [$clog2(N_HOLES)-1:0]      hit_idx,
  output logic [N_HOLES-1:0]              mole_mask,
  output logic                            hit_ok,
  output logic                            hit_bad,
  output logic                            expired,
  output logic [$clog2(MAX_ACTIVE+1)-1:0] active_cnt
);

  localparam int HW = $clog2(N_HOLES);
  localparam int CW = $clog2(MAX_ACTIVE + 1);
  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0]         pre;
  logic                  tick;
  logic [TW-1:0]         gap, dur;
  int unsigned           lim;
  logic [HW-1:0]         start, pick, probe;
  logic                  found, full;
  logic                  in_range, hit_hit;
  logic [MAX_ACTIVE-1:0] req, grant, expire, allowed;
  logic [HW-1:0]         hole [MAX_ACTIVE];
  logic [N_HOLES-1:0]    clr, set, mask_n;

  assign tick = enable && pre == PW'(TICK_DIV - 1);

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n)                pre <= '0;
    else if (!enable || tick)  pre <= '0;
    else                       pre <= pre + PW'(1);
  end

  assign lim = stage_limit(stage, MAX_ACTIVE);
  assign dur = TW'(stage_dur(stage, DUR_S1, DUR_S2, DUR_S3));
  assign gap = TW'(32'(rand_in) % stage_gap(stage, GAP_S1, GAP_S2, GAP_S3))
             + TW'(1);

  // Probe upward from a random hole, wrapping, for the first free one.
  assign start = HW'(32'(rand_in) % N_HOLES);
  always_comb begin
    found = 1'b0;
    pick  = '0;
    probe = '0;
    for (int k = 0; k < N_HOLES; k++) begin
      probe = HW'((32'(start) + 32'(k)) % N_HOLES);
      if (!found && !mole_mask[probe]) begin
        found = 1'b1;
        pick  = probe;
      end
    end
  end
  assign full = !found;

  always_comb begin
    logic taken;
    taken = 1'b0;
    grant = '0;
    for (int s = 0; s < MAX_ACTIVE; s++) begin
      if (req[s] && !taken) begin
        grant[s] = 1'b1;
        taken    = 1'b1;
      end
    end
  end

  assign in_range = 32'(hit_idx) < N_HOLES;
  assign hit_hit  = enable && hit_valid && in_range && mole_mask[hit_idx];

  for (genvar g = 0; g < MAX_ACTIVE; g++) begin : g_slot
    assign allowed[g] = 32'(g) < lim;
    mole_slot #(.TW(TW), .HW(HW)) u_slot (
      .clk        (clk_1mhz),
      .rst_n      (rst_n),
      .enable     (enable),
      .allowed    (allowed[g]),
      .tick       (tick),
      .gap        (gap),
      .dur        (dur),
      .grant      (grant[g]),
      .full       (full),
      .spawn_hole (pick),
      .hit_hit    (hit_hit),
      .hit_idx    (hit_idx),
      .req        (req[g]),
      .expire     (expire[g]),
      .hole       (hole[g])
    );
  end

  // Hits see the pre-edge mask, so a hit on a hole spawning now is bad.
  always_comb begin
    clr = '0;
    set = '0;
    if (hit_hit) clr[hit_idx] = 1'b1;
    for (int s = 0; s < MAX_ACTIVE; s++) begin
      if (expire[s]) clr[hole[s]] = 1'b1;
    end
    if (|grant && found) set[pick] = 1'b1;
    mask_n = (mole_mask & ~clr) | set;
  end

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      mole_mask  <= '0;
      hit_ok     <= 1'b0;
      hit_bad    <= 1'b0;
      expired    <= 1'b0;
      active_cnt <= '0;
    end else if (!enable) begin
      mole_mask  <= '0;
      hit_ok     <= 1'b0;
      hit_bad    <= 1'b0;
      expired    <= 1'b0;
      active_cnt <= '0;
    end else begin
      mole_mask  <= mask_n;
      hit_ok     <= hit_hit;
      hit_bad    <= hit_valid && !hit_hit;
      expired    <= |expire;
      active_cnt <= CW'($countones(mask_n));
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: directed scenarios plus random traffic,
// all checked every cycle against a behavioural per-slot ms model.
module tb_mole_scheduler;

  localparam int N  = 8;
  localparam int MA = 3;
  localparam int TD = 10;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] stage;
  logic [15:0] rand_in;
  logic       hit_valid;
  logic [2:0] hit_idx;
  logic [7:0] mole_mask;
  logic       hit_ok, hit_bad, expired;
  logic [1:0] active_cnt;

  int compared   = 0;
  int mismatched = 0;

  // Model: ms left in gap, ms left on show, hole, pending retry.
  int         m_pre;
  int         wl [MA];
  int         sl [MA];
  int         mh [MA];
  bit         rt [MA];
  logic [7:0] m_mask;
  bit         m_ok, m_bad, m_exp;
  int         m_cnt;

  mole_scheduler #(.TICK_DIV(TD)) dut (
    .clk_1mhz   (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .stage      (stage),
    .rand_in    (rand_in),
    .hit_valid  (hit_valid),
    .hit_idx    (hit_idx),
    .mole_mask  (mole_mask),
    .hit_ok     (hit_ok),
    .hit_bad    (hit_bad),
    .expired    (expired),
    .active_cnt (active_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    m_pre = 0;
    for (int s = 0; s < MA; s++) begin
      wl[s] = 0; sl[s] = 0; mh[s] = 0; rt[s] = 1'b0;
    end
    m_mask = '0; m_ok = 0; m_bad = 0; m_exp = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int st, lim, dur, gl, gap, start, h;
    bit tick, good, granted, ex;
    logic [7:0] old, nm;
    logic [2:0] p;
    if (!enable) begin
      m_clear();
      return;
    end
    tick  = (m_pre == TD - 1);
    m_pre = tick ? 0 : m_pre + 1;
    st  = (stage == 2'd0) ? 1 : int'(stage);
    lim = (st == 1) ? 1 : (st == 2) ? 2 : 3;
    dur = (st == 1) ? 1000 : (st == 2) ? 750 : 500;
    gl  = (st == 1) ? 500 : (st == 2) ? 250 : 200;
    gap = ((int'(rand_in) % gl) % 1024) + 1;
    old = m_mask;
    nm  = old;
    good = hit_valid && old[hit_idx];
    granted = 0;
    ex = 0;
    for (int s = 0; s < MA; s++) begin
      if (sl[s] > 0) begin
        if (good && mh[s] == int'(hit_idx)) begin
          nm[3'(mh[s])] = 1'b0;
          sl[s] = 0;
          wl[s] = (s < lim) ? gap : 0;
        end else if (tick && sl[s] == 1) begin
          nm[3'(mh[s])] = 1'b0;
          ex = 1;
          sl[s] = 0;
          wl[s] = (s < lim) ? gap : 0;
        end else if (tick) begin
          sl[s]--;
        end
      end else if (wl[s] > 0) begin
        if (s >= lim) begin
          wl[s] = 0;
          rt[s] = 0;
        end else if (rt[s] || (tick && wl[s] == 1)) begin
          if (!granted) begin
            granted = 1;
            rt[s] = 0;
            h = -1;
            start = int'(rand_in) % N;
            for (int k = 0; k < N; k++) begin
              p = 3'((start + k) % N);
              if (h < 0 && !old[p]) h = int'(p);
            end
            if (h >= 0) begin
              nm[3'(h)] = 1'b1;
              mh[s] = h;
              sl[s] = dur;
              wl[s] = 0;
            end
          end else begin
            rt[s] = 1;
          end
        end else if (tick) begin
          wl[s]--;
        end
      end else if (s < lim) begin
        wl[s] = gap;
      end
    end
    m_mask = nm;
    m_ok   = good;
    m_bad  = hit_valid && !good;
    m_exp  = ex;
    m_cnt  = $countones(nm);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) m_clear();
    else model_step();
    #1;
    chk("mole_mask", 32'(mole_mask), 32'(m_mask));
    chk("hit_ok", 32'(hit_ok), 32'(m_ok));
    chk("hit_bad", 32'(hit_bad), 32'(m_bad));
    chk("expired", 32'(expired), 32'(m_exp));
    chk("active_cnt", 32'(active_cnt), 32'(m_cnt));
  endtask

  initial begin
    int n, exps, h;
    rst_n = 1'b0; enable = 1'b0; stage = 2'd0;
    rand_in = '0; hit_valid = 1'b0; hit_idx = '0;
    m_clear();
    #2;
    chk("reset_mask", 32'(mole_mask), 32'h0);
    chk("reset_cnt", 32'(active_cnt), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Stage 1, fixed rand 3: hole 3 after 4 ms, shown 1000 ms.
    stage = 2'd1; rand_in = 16'h0003; enable = 1'b1;
    for (n = 0; n < 100; n++) begin
      step();
      if (mole_mask != 0) break;
    end
    chk("first_spawn_cycle", 32'(n), 32'd39);
    chk("first_spawn_mask", 32'(mole_mask), 32'h08);
    exps = 0;
    for (n = 0; n < 10100; n++) begin
      step();
      if (expired) exps++;
      if (mole_mask == 0) break;
    end
    chk("show_len", 32'(n + 1), 32'd10000);
    chk("expire_count", 32'(exps), 32'd1);
    chk("expire_at_clear", 32'(expired), 32'd1);

    // Stage 3, rand 0: probe collisions fill holes 0,1,2.
    enable = 1'b0;
    step();
    stage = 2'd3; rand_in = 16'h0000; enable = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("s3_before_tick", 32'(mole_mask), 32'h00);
    step();
    chk("s3_fill0", 32'(mole_mask), 32'h01);
    step();
    chk("s3_fill1", 32'(mole_mask), 32'h03);
    step();
    chk("s3_fill2", 32'(mole_mask), 32'h07);
    chk("s3_cnt", 32'(active_cnt), 32'd3);

    // Mole at hole 5: miss on hole 2, then hit it.
    enable = 1'b0;
    step();
    stage = 2'd1; rand_in = 16'd5; enable = 1'b1;
    for (n = 0; n < 200; n++) begin
      step();
      if (mole_mask != 0) break;
    end
    chk("h5_mask", 32'(mole_mask), 32'h20);
    hit_idx = 3'd2; hit_valid = 1'b1;
    step();
    hit_valid = 1'b0;
    chk("bad_pulse", 32'(hit_bad), 32'd1);
    chk("bad_mask", 32'(mole_mask), 32'h20);
    step();
    chk("bad_width", 32'(hit_bad), 32'd0);
    hit_idx = 3'd5; hit_valid = 1'b1;
    step();
    hit_valid = 1'b0;
    chk("ok_pulse", 32'(hit_ok), 32'd1);
    chk("ok_mask", 32'(mole_mask), 32'h00);
    step();
    chk("ok_width", 32'(hit_ok), 32'd0);
    exps = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (expired) exps++;
    end
    chk("hit_no_expire", 32'(exps), 32'd0);

    // Hit in the exact expiry cycle; stage drop keeps running timer.
    enable = 1'b0;
    step();
    stage = 2'd3; rand_in = 16'd3; enable = 1'b1;
    for (n = 0; n < 100; n++) begin
      step();
      if (mole_mask != 0) break;
    end
    chk("s3_spawn_cycle", 32'(n), 32'd39);
    chk("s3_spawn_mask", 32'(mole_mask), 32'h08);
    stage = 2'd1;
    for (int i = 0; i < 4999; i++) step();
    chk("pre_expiry_mask", 32'(mole_mask), 32'h08);
    hit_idx = 3'd3; hit_valid = 1'b1;
    step();
    hit_valid = 1'b0;
    chk("race_hit_ok", 32'(hit_ok), 32'd1);
    chk("race_expired", 32'(expired), 32'd0);
    chk("race_mask", 32'(mole_mask), 32'h00);

    // Enable drop mid-show, re-enable, then async reset pulse.
    for (n = 0; n < 100; n++) begin
      step();
      if (mole_mask != 0) break;
    end
    chk("respawn_mask", 32'(mole_mask), 32'h08);
    enable = 1'b0;
    step();
    chk("en_drop_mask", 32'(mole_mask), 32'h00);
    enable = 1'b1;
    for (n = 0; n < 100; n++) begin
      step();
      if (mole_mask != 0) break;
    end
    chk("reenable_cycle", 32'(n), 32'd39);
    #2;
    rst_n = 1'b0;
    m_clear();
    #1;
    chk("async_rst_mask", 32'(mole_mask), 32'h00);
    step();
    rst_n = 1'b1;
    step();

    // Random traffic.
    for (int i = 0; i < 20000; i++) begin
      rand_in = 16'($urandom);
      if (i % 2500 == 0) stage = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 4999) != 0);
      hit_valid = ($urandom_range(0, 29) == 0);
      h = $urandom_range(0, 7);
      if (m_mask != 0 && $urandom_range(0, 2) != 0) begin
        while (!m_mask[3'(h)]) h = (h + 1) % N;
      end
      hit_idx = 3'(h);
      step();
    end
    hit_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
